// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: pops bytes from the async FIFO read port and packs them little-endian into valid/ready words,
// flushing a partial word after an idle timeout.
module fifo_rd_packer #(
    parameter int Data_Width = 8,
    parameter int Pack_Ratio = 4,
    parameter int Timeout    = 16
) (
    input  logic                             rclk,
    input  logic                             rrst,
    input  logic                             rempty,
    input  logic [Data_Width-1:0]            rdata,
    output logic                             rinc,
    output logic [Data_Width*Pack_Ratio-1:0] m_data,
    output logic [Pack_Ratio-1:0]            m_keep,
    output logic                             m_valid,
    input  logic                             m_ready
);
    localparam int WW = Data_Width * Pack_Ratio;
    localparam int CW = $clog2(Pack_Ratio + 1);
    localparam int IW = $clog2(Timeout + 1);
    localparam logic [CW-1:0] FULL = CW'(Pack_Ratio);
    localparam logic [IW-1:0] IDLE_LAST = IW'(Timeout - 2);

    typedef enum logic [1:0] {EMPTY, FILL, HOLD} state_t;

    state_t              state_q, state_d;
    logic [WW-1:0]       acc_q, acc_d, acc_w, data_q, data_d;
    logic [CW-1:0]       cnt_q, cnt_d, cnt_w;
    logic [Pack_Ratio-1:0] keep_q, keep_d, keep_w;
    logic [IW-1:0]       idle_q, idle_d;
    logic                pend_q, valid_q, valid_d, free, idle_tick, load;

    // counting the in-flight byte keeps a pop from overrunning the accumulator
    assign rinc = !rrst && !rempty && (cnt_q + CW'(pend_q) < FULL) && state_q != HOLD;
    assign free = !valid_q || m_ready;
    assign idle_tick = state_q == FILL && !pend_q && !rinc;
    assign m_data = data_q;
    assign m_keep = keep_q;
    assign m_valid = valid_q;

    always_comb begin
        acc_w = acc_q;
        for (int i = 0; i < Pack_Ratio; i++)
            if (pend_q && cnt_q == CW'(i)) acc_w[i*Data_Width +: Data_Width] = rdata;
        cnt_w = cnt_q + CW'(pend_q);
        for (int i = 0; i < Pack_Ratio; i++) keep_w[i] = CW'(i) < cnt_w;
        load = 1'b0;
        state_d = state_q;
        case (state_q)
            EMPTY: state_d = pend_q ? FILL : EMPTY;
            FILL: begin
                if (cnt_w == FULL) begin
                    load = free;
                    state_d = HOLD;
                end else if (idle_tick && idle_q == IDLE_LAST) begin
                    state_d = HOLD;
                end
            end
            HOLD: load = free;
            default: state_d = EMPTY;
        endcase
        // a transfer empties the accumulator whether the word is full or flushed
        state_d = load ? EMPTY : state_d;
        idle_d = (idle_tick && state_d == FILL) ? idle_q + IW'(1) : '0;
        acc_d = load ? '0 : acc_w;
        cnt_d = load ? '0 : cnt_w;
        valid_d = load || (valid_q && !m_ready);
        data_d = load ? acc_w : data_q;
        keep_d = load ? keep_w : keep_q;
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            state_q <= EMPTY;
            acc_q <= '0;
            cnt_q <= '0;
            idle_q <= '0;
            pend_q <= 1'b0;
            valid_q <= 1'b0;
            data_q <= '0;
            keep_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            idle_q <= idle_d;
            pend_q <= rinc;
            valid_q <= valid_d;
            data_q <= data_d;
            keep_q <= keep_d;
        end
    end
endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb_fifo_rd_packer: byte FIFO model feeding the packer, scoreboard of expected words, timing and invariant checks.
module tb_fifo_rd_packer;
    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        int          lat;
    } exp_t;

    logic        rclk = 1'b0;
    logic        rrst = 1'b1;
    logic        rempty = 1'b1;
    logic [7:0]  rdata = '0;
    logic        rinc;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        m_valid;
    logic        m_ready = 1'b1;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int pops = 0;
    int last_cap = 0;
    int rise_cyc = 0;
    logic prev_pop = 1'b0;
    logic valid_prev = 1'b0;
    logic hold_pend = 1'b0;
    logic [31:0] held_d;
    logic [3:0] held_k;
    logic rand_empty = 1'b0;
    logic rand_ready = 1'b0;
    logic [7:0] fifo[$];
    exp_t sb[$];

    fifo_rd_packer dut (
        .rclk(rclk), .rrst(rrst), .rempty(rempty), .rdata(rdata), .rinc(rinc),
        .m_data(m_data), .m_keep(m_keep), .m_valid(m_valid), .m_ready(m_ready)
    );

    always #5 rclk = ~rclk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fifo.push_back(b);
        rempty = 1'b0;
    endtask

    task automatic expect_word(input logic [31:0] d, input logic [3:0] k, input int lat);
        exp_t e;
        e.d = d;
        e.k = k;
        e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic tick();
        logic pop;
        exp_t e;
        @(negedge rclk);
        chk("rinc_while_empty", 64'(rinc && rempty), 0);
        if (rrst) chk("rinc_in_reset", 64'(rinc), 0);
        if (hold_pend) begin
            chk("hold_data", 64'(m_data), 64'(held_d));
            chk("hold_keep", 64'(m_keep), 64'(held_k));
        end
        hold_pend = m_valid && !m_ready && !rrst;
        held_d = m_data;
        held_k = m_keep;
        pop = rinc && !rempty;
        if (m_valid && m_ready && !rrst) begin
            if (sb.size() == 0) begin
                chk("unexpected_word", 64'(m_data), 0);
            end else begin
                e = sb.pop_front();
                chk("word_data", 64'(m_data), 64'(e.d));
                chk("word_keep", 64'(m_keep), 64'(e.k));
                if (e.lat >= 0) chk("flush_latency", 64'(rise_cyc - last_cap), 64'(e.lat));
            end
        end
        @(posedge rclk);
        cyc++;
        if (prev_pop && !rrst) last_cap = cyc;
        prev_pop = pop && !rrst;
        #1;
        if (pop && fifo.size() != 0) begin
            pops++;
            rdata = fifo.pop_front();
        end
        if (m_valid && !valid_prev) rise_cyc = cyc;
        valid_prev = m_valid;
        rempty = fifo.size() == 0 || (rand_empty && $urandom_range(0, 2) == 0);
        if (rand_ready) m_ready = $urandom_range(0, 3) != 0;
    endtask

    task automatic drain(input string tag);
        for (int n = 0; n < 300 && (sb.size() != 0 || m_valid); n++) tick();
        chk(tag, 64'(sb.size()), 0);
    endtask

    initial begin
        int p0;
        logic [31:0] w;
        tick();
        tick();
        chk("rst_valid", 64'(m_valid), 0);
        chk("rst_data", 64'(m_data), 0);
        chk("rst_keep", 64'(m_keep), 0);
        chk("rst_rinc", 64'(rinc), 0);
        rrst = 1'b0;
        tick();

        // 8-byte burst at full rate
        p0 = pops;
        for (int i = 1; i <= 8; i++) push(8'(i));
        expect_word(32'h04030201, 4'hF, -1);
        expect_word(32'h08070605, 4'hF, -1);
        drain("burst_drain");
        chk("burst_pops", 64'(pops - p0), 8);

        // backpressure: one word in the output register, one in the accumulator
        p0 = pops;
        m_ready = 1'b0;
        for (int i = 1; i <= 12; i++) push(8'(i));
        expect_word(32'h04030201, 4'hF, -1);
        expect_word(32'h08070605, 4'hF, -1);
        expect_word(32'h0C0B0A09, 4'hF, -1);
        for (int i = 0; i < 20; i++) tick();
        #1;
        chk("bp_pops", 64'(pops - p0), 8);
        chk("bp_valid", 64'(m_valid), 1);
        chk("bp_data", 64'(m_data), 64'h04030201);
        chk("bp_rinc", 64'(rinc), 0);
        m_ready = 1'b1;
        drain("bp_drain");

        // partial flush after the idle timeout
        push(8'hAA);
        push(8'hBB);
        push(8'hCC);
        expect_word(32'h00CCBBAA, 4'b0111, 16);
        drain("flush_drain");

        // a late second byte restarts the idle count
        push(8'h11);
        expect_word(32'h00002211, 4'b0011, 16);
        for (int i = 0; i < 12; i++) tick();
        chk("restart_early", 64'(m_valid), 0);
        push(8'h22);
        drain("restart_drain");

        // reset with two bytes captured and one in flight
        for (int i = 0; i < 8; i++) push(8'h31 + 8'(i));
        p0 = pops;
        for (int n = 0; n < 20 && pops - p0 < 3; n++) tick();
        chk("rst_mid_pops", 64'(pops - p0), 3);
        rrst = 1'b1;
        tick();
        chk("rst_mid_valid", 64'(m_valid), 0);
        chk("rst_mid_keep", 64'(m_keep), 0);
        rrst = 1'b0;
        hold_pend = 1'b0;
        expect_word(32'h37363534, 4'hF, -1);
        expect_word(32'h00000038, 4'b0001, 16);
        drain("rst_mid_drain");

        // random empty flag and ready
        rand_empty = 1'b1;
        rand_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            for (int i = 0; i < 4; i++) begin
                w[i*8 +: 8] = 8'($urandom);
                push(w[i*8 +: 8]);
            end
            expect_word(w, 4'hF, -1);
        end
        drain("rand_drain");
        rand_empty = 1'b0;
        rand_ready = 1'b0;
        m_ready = 1'b1;
        tick();
        chk("final_fifo_empty", 64'(fifo.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
